// File: rtl/w_input_conditioner_pkg.sv
// Shared constants for the switch-conditioning / sequence-detector FSM family.
// The state encoding is common so the downstream FSMs decode the same values.
package w_input_conditioner_pkg;

  typedef enum logic [1:0] {
    LOW        = 2'b00,
    CHECK_HIGH = 2'b01,
    HIGH       = 2'b10,
    CHECK_LOW  = 2'b11
  } db_state_e;

  // $clog2 gives 0 for n<=1; a counter still needs at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/w_input_conditioner_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; only q_o is safe to use.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/w_input_conditioner.sv
// Synchronizes and debounces a raw switch into w, with edge pulses and a
// free-running sample strobe for the downstream sequence detector.
module w_input_conditioner
  import w_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SAMPLE_DIV      = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      sw_raw,
  output logic      w,
  output logic      w_valid,
  output logic      rise_pulse,
  output logic      fall_pulse,
  output db_state_e dbg_state_o
);

  localparam int unsigned CNT_W = clog2_min1(DEBOUNCE_CYCLES);
  localparam int unsigned DIV_W = clog2_min1(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic             s;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise_q;
  logic             fall_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             w_valid_q;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sw_raw),
    .q_o   (s)
  );

  // The counter is cleared on entry to a CHECK state and saturates at
  // CNT_LAST, where the transition fires instead of incrementing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        LOW: begin
          if (s) begin
            state_q <= CHECK_HIGH;
            cnt_q   <= '0;
          end
        end
        CHECK_HIGH: begin
          if (!s) begin
            state_q <= LOW;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HIGH;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!s) begin
            state_q <= CHECK_LOW;
            cnt_q   <= '0;
          end
        end
        CHECK_LOW: begin
          if (s) begin
            state_q <= HIGH;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= LOW;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= LOW;
      endcase
    end
  end

  assign div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

  // Strobe is registered from the next count so it stays low in reset
  // even when SAMPLE_DIV is 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      w_valid_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      w_valid_q <= (div_d == DIV_LAST);
    end
  end

  assign w           = state_q[1];
  assign w_valid     = w_valid_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/w_input_conditioner.md
W_INPUT_CONDITIONER -- requirements
Module: w_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-stable cycles required to accept a level change; legal range >= 2.
REQ-002 The block SHALL have parameter SAMPLE_DIV, default 4: period of the w_valid strobe in clk cycles; legal range >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port sw_raw, input, 1 bit: raw asynchronous switch/pushbutton level.
REQ-006 The block SHALL have port w, output, 1 bit: debounced level, fed to the downstream sequence-detector FSM input w.
REQ-007 The block SHALL have port w_valid, output, 1 bit: one-cycle sample strobe every SAMPLE_DIV cycles.
REQ-008 The block SHALL have port rise_pulse, output, 1 bit: one-cycle pulse on accepted 0->1 change of w.
REQ-009 The block SHALL have port fall_pulse, output, 1 bit: one-cycle pulse on accepted 1->0 change of w.

Function
REQ-010 sw_raw SHALL pass through a 2-flop synchronizer; only the second flop output (s) feeds further logic.
REQ-011 The debounce FSM SHALL have states LOW=2'b00, CHECK_HIGH=2'b01, HIGH=2'b10, CHECK_LOW=2'b11.
REQ-012 LOW: s=1 -> CHECK_HIGH with debounce counter cleared to 0; else stay.
REQ-013 CHECK_HIGH: s=0 -> LOW; s=1 and counter==DEBOUNCE_CYCLES-1 -> HIGH; s=1 otherwise -> stay, counter+1.
REQ-014 HIGH and CHECK_LOW SHALL mirror LOW and CHECK_HIGH with s inverted (HIGH: s=0 -> CHECK_LOW; CHECK_LOW: s=1 -> HIGH, s=0 at terminal count -> LOW).
REQ-015 w SHALL equal state bit 1 (high in HIGH and CHECK_LOW); no combinational decode beyond that bit.
REQ-016 Latency: sw_raw stable from before edge k -> w changes after edge k+DEBOUNCE_CYCLES+2 (4 defaults: k+6).
REQ-017 Any glitch in CHECK_* shorter than DEBOUNCE_CYCLES synchronized cycles SHALL return the FSM to its prior stable state with no change on w or pulses.
REQ-018 rise_pulse SHALL be a register, high for exactly the one cycle following a CHECK_HIGH->HIGH transition; fall_pulse likewise for CHECK_LOW->LOW; never both high.
REQ-019 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap.
REQ-020 Sample divider SHALL count 0..SAMPLE_DIV-1 and wrap to 0, free-running, independent of sw_raw; w_valid high when count==SAMPLE_DIV-1; SAMPLE_DIV=1 gives w_valid constantly 1 after first edge.
REQ-021 Simultaneous terminal count and divider wrap SHALL both take effect in the same cycle with no interaction.

Reset
REQ-022 reset SHALL asynchronously force: synchronizer flops 0, state LOW, both counters 0, w=0, w_valid=0, rise_pulse=0, fall_pulse=0.
REQ-023 Reset asserted mid-check SHALL abandon the pending transition; after release the block SHALL behave as from power-up (full debounce latency again).

Structure
REQ-024 State encodings (LOW, CHECK_HIGH, HIGH, CHECK_LOW) SHALL reside in a shared constants package/include also used by the downstream FSM family.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, async reset to 0); debounce FSM and divider stay in the top module.

Verification (DEBOUNCE_CYCLES=4, SAMPLE_DIV=4)
REQ-026 Release reset, sw_raw held 0 for 20 cycles -> w=0, no pulses; w_valid high after edges 3, 7, 11, 15, 19 only.
REQ-027 sw_raw 0->1 before edge 1, held -> w rises after edge 7; rise_pulse high only between edges 7 and 8.
REQ-028 With w=1, sw_raw 1->0 before edge k, held -> w falls after edge k+6; single fall_pulse cycle.
REQ-029 Bounce: sw_raw 1 for 2 cycles, 0 for 1, 1 for 2, then 0 -> w stays 0, no rise_pulse, FSM ends in LOW.
REQ-030 Reset asserted 2 cycles into CHECK_HIGH, released, sw_raw held 1 -> w rises 7 edges after release, not earlier.
REQ-031 Chained with downstream detector: three accepted rises of w, each held >= 2 detector clocks -> detector z=1 while w stays 1, z=0 within one cycle after w falls.
